// File: rtl/intern_sync_mc_if.sv
// Requester/resource handshake bundle for the intern_sync_mc arbiter.
// master = requester/testbench side, slave = arbiter side.
interface intern_sync_mc_if #(
  parameter int NCH = 4,
  parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic           rc_is_idle;
  logic [NCH-1:0] rc_reqn;
  logic [NCH-1:0] rc_ackn;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic           tmo_err;

  modport master (
    output rc_is_idle, rc_reqn,
    input  rc_ackn, busy, grant_id, tmo_err
  );

  modport slave (
    input  rc_is_idle, rc_reqn,
    output rc_ackn, busy, grant_id, tmo_err
  );
endinterface

// File: rtl/intern_sync_mc.sv
// Round-robin arbiter granting a shared resource to NCH requesters once the
// resource has reported idle for IDLE_STB consecutive cycles, with timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no channel served; arbitrate when any rc_reqn bit is low
// S_WAIT | channel grant_id selected; waiting for stable rc_is_idle
// S_ACK  | idle condition met; ack pulse is registered for next cycle
module intern_sync_mc #(
  parameter int NCH      = 4,
  parameter int IDLE_STB = 2,
  parameter int TMO      = 64,
  parameter int TMO_W    = 12,
  parameter int IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic clk,
  input  logic rst,
  intern_sync_mc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0]       STB_MAX  = 4'(IDLE_STB);
  localparam logic [3:0]       STB_LAST = 4'(IDLE_STB - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   grant_q, grant_nxt;
  logic [IDW-1:0]   last_q, last_nxt;
  logic [3:0]       stb_q, stb_nxt;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic [NCH-1:0]   ackn_q, ackn_nxt;
  logic             tmo_err_q, tmo_err_nxt;
  logic             req_any;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;

  // Round-robin pick: first requesting channel after last_grant (lowest offset wins).
  always_comb begin
    req_any = ~&bus.rc_reqn;
    pick    = grant_q;
    cand    = '0;
    for (int i = NCH; i >= 1; i--) begin
      cand = IDW'((int'(last_q) + i) % NCH);
      if (!bus.rc_reqn[cand]) pick = cand;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    last_nxt    = last_q;
    stb_nxt     = stb_q;
    tmo_nxt     = tmo_q;
    ackn_nxt    = '1;
    tmo_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        stb_nxt = '0;
        tmo_nxt = '0;
        if (req_any) begin
          grant_nxt = pick;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo_q + TMO_W'(1);
        if (bus.rc_is_idle) stb_nxt = (stb_q == STB_MAX) ? stb_q : stb_q + 4'd1;
        else                stb_nxt = '0;
        // Withdrawal beats ack, ack beats timeout.
        if (bus.rc_reqn[grant_q]) begin
          state_nxt = S_IDLE;
          last_nxt  = grant_q;
        end else if (bus.rc_is_idle && stb_q == STB_LAST) begin
          state_nxt = S_ACK;
          last_nxt  = grant_q;
        end else if (tmo_q == TMO_LAST) begin
          state_nxt   = S_IDLE;
          last_nxt    = grant_q;
          tmo_err_nxt = 1'b1;
        end
        if (state_nxt != S_WAIT) begin
          stb_nxt = '0;
          tmo_nxt = '0;
        end
      end
      S_ACK: begin
        stb_nxt   = '0;
        tmo_nxt   = '0;
        ackn_nxt  = ~(NCH'(1) << grant_q);
        state_nxt = S_IDLE;
      end
      default: begin
        stb_nxt   = '0;
        tmo_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_q   <= '0;
      last_q    <= IDW'(NCH - 1);
      stb_q     <= '0;
      tmo_q     <= '0;
      ackn_q    <= '1;
      tmo_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      last_q    <= last_nxt;
      stb_q     <= stb_nxt;
      tmo_q     <= tmo_nxt;
      ackn_q    <= ackn_nxt;
      tmo_err_q <= tmo_err_nxt;
    end
  end

  assign bus.rc_ackn  = ackn_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.grant_id = grant_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_intern_sync_mc.sv
// Self-checking bench for intern_sync_mc: directed scenarios plus randomized
// runs compared against a transaction-level model of grant/ack/timeout timing.
module tb_intern_sync_mc;
  localparam int NCH      = 4;
  localparam int IDLE_STB = 2;
  localparam int TMO      = 8;
  localparam int IDW      = 2;
  localparam int N        = 60;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic           idl     [N+TMO+4];
  logic [NCH-1:0] exp_ack [N];
  logic           exp_tmo [N];

  intern_sync_mc_if #(.NCH(NCH), .IDW(IDW)) bus ();

  intern_sync_mc #(.NCH(NCH), .IDLE_STB(IDLE_STB), .TMO(TMO), .TMO_W(12), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rc_reqn = '1;
    bus.rc_is_idle = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rc_reqn = '0;
    bus.rc_is_idle = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (bus.rc_ackn !== 4'b1111) begin n_fail++; $display("FAIL reset_ackn got=%b want=1111", bus.rc_ackn); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_checks++;
    if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d want=0", bus.grant_id); end
    n_checks++;
    if (bus.tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got=%b want=0", bus.tmo_err); end
    bus.rc_reqn = '1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    bus.rc_reqn = 4'b1110;
    bus.rc_is_idle = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy got=%b want=1", bus.busy); end
    n_checks++;
    if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL lat_grant got=%0d want=0", bus.grant_id); end
    for (int t = 1; t <= 4; t++) begin
      if (t == 4) bus.rc_reqn = 4'b1111;
      tick();
      n_checks++;
      if (bus.rc_ackn !== ((t == 3) ? 4'b1110 : 4'b1111)) begin
        n_fail++; $display("FAIL lat_ackn edge=%0d got=%b want=%b", t, bus.rc_ackn, (t == 3) ? 4'b1110 : 4'b1111);
      end
    end
    bus.rc_reqn = '1;
  endtask

  task automatic test_round_robin();
    int k;
    logic [NCH-1:0] a;
    do_reset();
    bus.rc_reqn = '0;
    bus.rc_is_idle = 1'b1;
    k = 0;
    for (int t = 0; t < 22; t++) begin
      tick();
      a = bus.rc_ackn;
      n_checks++;
      if ($countones(~a) > 1) begin n_fail++; $display("FAIL rr_onehot t=%0d got=%b want at most one low", t, a); end
      if (a != 4'b1111) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (!a[ch]) begin
            n_checks++;
            if (ch != k % NCH) begin n_fail++; $display("FAIL rr_order ack#%0d got=ch%0d want=ch%0d", k, ch, k % NCH); end
          end
        end
        k++;
      end
    end
    n_checks++;
    if (k != 5) begin n_fail++; $display("FAIL rr_count got=%0d want=5", k); end
    bus.rc_reqn = '1;
  endtask

  task automatic test_idle_filter();
    logic seq [4];
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b1;
    do_reset();
    bus.rc_reqn = 4'b1101;
    bus.rc_is_idle = 1'b0;
    tick();
    n_checks++;
    if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL filt_grant got=%0d want=1", bus.grant_id); end
    for (int t = 0; t < 4; t++) begin
      bus.rc_is_idle = seq[t];
      tick();
      n_checks++;
      if (bus.rc_ackn !== 4'b1111) begin n_fail++; $display("FAIL filt_early edge=%0d got=%b want=1111", t + 1, bus.rc_ackn); end
    end
    tick();
    n_checks++;
    if (bus.rc_ackn !== 4'b1101) begin n_fail++; $display("FAIL filt_ack got=%b want=1101", bus.rc_ackn); end
    bus.rc_reqn = '1;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.rc_reqn = 4'b1100;
    bus.rc_is_idle = 1'b0;
    tick();
    n_checks++;
    if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL tmo_grant0 got=%0d want=0", bus.grant_id); end
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_checks++;
      if (bus.tmo_err !== (t == 8)) begin n_fail++; $display("FAIL tmo_pulse edge=%0d got=%b want=%b", t, bus.tmo_err, (t == 8)); end
      n_checks++;
      if (bus.rc_ackn !== 4'b1111) begin n_fail++; $display("FAIL tmo_noack edge=%0d got=%b want=1111", t, bus.rc_ackn); end
    end
    tick();
    n_checks++;
    if (bus.tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_single got=%b want=0", bus.tmo_err); end
    n_checks++;
    if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL tmo_next grant=%0d busy=%b want grant=1 busy=1", bus.grant_id, bus.busy);
    end
    bus.rc_reqn = '1;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.rc_reqn = 4'b1011;
    bus.rc_is_idle = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin
      n_fail++; $display("FAIL wd_enter busy=%b grant=%0d want busy=1 grant=2", bus.busy, bus.grant_id);
    end
    bus.rc_reqn = 4'b1111;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wd_idle got=%b want=0", bus.busy); end
    for (int t = 0; t < 6; t++) begin
      tick();
      n_checks++;
      if (bus.rc_ackn !== 4'b1111 || bus.tmo_err !== 1'b0) begin
        n_fail++; $display("FAIL wd_quiet t=%0d ackn=%b tmo=%b want 1111/0", t, bus.rc_ackn, bus.tmo_err);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.rc_reqn = 4'b0111;
    bus.rc_is_idle = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rc_ackn !== 4'b1111 || bus.grant_id !== 2'd0 || bus.tmo_err !== 1'b0) begin
      n_fail++; $display("FAIL async_rst busy=%b ackn=%b grant=%0d tmo=%b want 0/1111/0/0", bus.busy, bus.rc_ackn, bus.grant_id, bus.tmo_err);
    end
    #2 rst = 1'b0;
    bus.rc_reqn = 4'b1011;
    tick();
    n_checks++;
    if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL async_regrant grant=%0d busy=%b want 2/1", bus.grant_id, bus.busy);
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if (bus.rc_ackn !== ((t == 3) ? 4'b1011 : 4'b1111)) begin
        n_fail++; $display("FAIL async_ack edge=%0d got=%b want=%b", t, bus.rc_ackn, (t == 3) ? 4'b1011 : 4'b1111);
      end
    end
    bus.rc_reqn = '1;
  endtask

  // Randomized run: requesters hold a fixed mask, resource idle is random.
  // Expected acks and timeouts are derived from the idle-run rule per grant.
  task automatic test_random(int run);
    logic [NCH-1:0] mask;
    int p, e, c, j_ack;
    logic ok;
    for (int t = 0; t < N + TMO + 4; t++) idl[t] = ($urandom_range(0, 3) != 0);
    mask = 4'($urandom_range(1, 15));
    for (int t = 0; t < N; t++) begin exp_ack[t] = '1; exp_tmo[t] = 1'b0; end
    p = NCH - 1;
    e = 0;
    while (e < N) begin
      c = 0;
      for (int i = NCH; i >= 1; i--) if (mask[2'((p + i) % NCH)]) c = (p + i) % NCH;
      j_ack = 0;
      for (int j = IDLE_STB; j <= TMO && j_ack == 0; j++) begin
        ok = 1'b1;
        for (int m = j - IDLE_STB + 1; m <= j; m++) if (!idl[e + m]) ok = 1'b0;
        if (ok) j_ack = j;
      end
      if (j_ack != 0) begin
        if (e + j_ack + 1 < N) exp_ack[e + j_ack + 1][2'(c)] = 1'b0;
        e = e + j_ack + 2;
      end else begin
        if (e + TMO < N) exp_tmo[e + TMO] = 1'b1;
        e = e + TMO + 1;
      end
      p = c;
    end
    do_reset();
    for (int t = 0; t < N; t++) begin
      bus.rc_reqn = ~mask;
      bus.rc_is_idle = idl[t];
      tick();
      n_checks++;
      if (bus.rc_ackn !== exp_ack[t]) begin
        n_fail++; $display("FAIL rand_ackn run=%0d edge=%0d got=%b want=%b", run, t, bus.rc_ackn, exp_ack[t]);
      end
      n_checks++;
      if (bus.tmo_err !== exp_tmo[t]) begin
        n_fail++; $display("FAIL rand_tmo run=%0d edge=%0d got=%b want=%b", run, t, bus.tmo_err, exp_tmo[t]);
      end
    end
    bus.rc_reqn = '1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.rc_reqn = '1;
    bus.rc_is_idle = 1'b0;
    test_reset();
    test_latency();
    test_round_robin();
    test_idle_filter();
    test_timeout();
    test_withdraw();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intern_sync_mc.md
INTERN_SYNC_MC -- requirements
Module: intern_sync_mc

Interface
REQ-001 Parameter NCH, default 4, number of requester channels (1..16).
REQ-002 Parameter IDLE_STB, default 2, consecutive rc_is_idle=1 cycles required before ack (1..15).
REQ-003 Parameter TMO, default 64, maximum WAIT cycles before abort (2..4095); TMO_W = 12.
REQ-004 Parameter IDW = max(1, clog2(NCH)), width of the grant index.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rc_is_idle  input  1  shared resource idle indication, sampled on clk.
REQ-008 rc_reqn  input  NCH  per-channel active-low request, level held by requester.
REQ-009 rc_ackn  output  NCH  per-channel active-low acknowledge, registered.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 grant_id  output  IDW  index of channel currently served; holds last value in IDLE.
REQ-012 tmo_err  output  1  one-cycle high pulse on timeout abort.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, ACK; one-hot or binary encoding is free, illegal codes SHALL return to IDLE next cycle.
REQ-014 IDLE: if any rc_reqn bit is 0, SHALL select a channel round-robin starting at (last_grant+1) mod NCH, load grant_id, clear stb_cnt and tmo_cnt, go to WAIT.
REQ-015 IDLE with all rc_reqn=1: SHALL remain IDLE, counters held at 0.
REQ-016 WAIT: stb_cnt SHALL increment (saturating at IDLE_STB) each cycle rc_is_idle=1 and clear to 0 each cycle rc_is_idle=0.
REQ-017 WAIT: when rc_is_idle=1 and stb_cnt=IDLE_STB-1, SHALL go to ACK next cycle.
REQ-018 WAIT: tmo_cnt SHALL increment every cycle; when tmo_cnt=TMO-1 without the ACK condition, SHALL go to IDLE, pulse tmo_err for one cycle, no ack issued.
REQ-019 WAIT: if rc_reqn[grant_id] returns to 1, SHALL go to IDLE without ack or tmo_err (withdrawal has priority over ack and timeout in the same cycle).
REQ-020 Same-cycle ACK condition and timeout: ACK wins.
REQ-021 ACK: rc_ackn[grant_id] SHALL be 0 for exactly this one cycle; all other rc_ackn bits SHALL stay 1; next state IDLE.
REQ-022 At most one rc_ackn bit SHALL be 0 in any cycle.
REQ-023 last_grant SHALL update to grant_id on leaving WAIT (ack, timeout or withdrawal), guaranteeing round-robin fairness.
REQ-024 A requester still holding rc_reqn=0 after its ack SHALL be re-eligible only in round-robin order.
REQ-025 Latency: request first sampled in IDLE at edge k, rc_is_idle=1 constantly -> rc_ackn low during cycle after edge k+IDLE_STB+1.
REQ-026 Round-robin wrap-around: pointer after NCH-1 SHALL be 0; NCH=1 SHALL always grant channel 0.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force state IDLE, rc_ackn all 1, busy=0, grant_id=0, last_grant=NCH-1, tmo_err=0, counters 0.
REQ-028 Reset asserted mid-WAIT or mid-ACK SHALL abort without ack; first arbitration after release SHALL start at channel 0.
REQ-029 Deassertion of rst SHALL take effect on the next clk rising edge; inputs are ignored while rst=1.

Verification
REQ-030 NCH=4, IDLE_STB=2, rc_is_idle=1, rc_reqn=4'b1110 at edge 0 -> busy=1 after edge 0, rc_ackn=4'b1110 one cycle after edge 3, then 4'b1111.
REQ-031 All four rc_reqn=0 held, rc_is_idle=1 -> acks in order ch0,ch1,ch2,ch3,ch0, each one cycle, never two at once.
REQ-032 rc_is_idle toggling 1,0,1,1 during WAIT with IDLE_STB=2 -> ack only after the final two consecutive 1s.
REQ-033 rc_is_idle=0 held, TMO=8 -> tmo_err pulses once 8 cycles after WAIT entry, no rc_ackn low, next grant goes to next channel.
REQ-034 Requester withdraws (rc_reqn back to 1) in WAIT cycle 1 -> return to IDLE, no ack, no tmo_err.
REQ-035 rst pulsed asynchronously mid-WAIT (between edges) -> outputs to reset values before next edge; subsequent request on ch2 only granted ch2 with correct latency.
